// File: rtl/rs232_tx_queue.sv
// Byte queue and launch sequencer that feeds an RS-232 serializer, one frame at a time.
// Optional: define RS232_TXQ_OVERFLOW_EN to add a sticky overflow output.
module rs232_tx_queue #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    wr_data,
  input  logic          wr_en,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic [7:0]    TxD_in,
  output logic          TxD_start,
  input  logic          busy
`ifdef RS232_TXQ_OVERFLOW_EN
  ,
  output logic          overflow
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    HOLD   = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          wr_acc;
  logic          pop;
  logic [7:0]    txd_in_nxt;
  logic          txd_start_nxt;
  logic [AW:0]   level_nxt;

  // A write arriving while full is dropped even if a pop frees a slot on the same edge.
  assign wr_acc = wr_en & ~full;

  // Next-state, launch and pop decode.
  always_comb begin
    state_nxt     = state;
    txd_start_nxt = 1'b0;
    txd_in_nxt    = TxD_in;
    pop           = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !busy) begin
          txd_in_nxt    = mem[rptr];
          txd_start_nxt = 1'b1;
          pop           = 1'b1;
          state_nxt     = LAUNCH;
        end else begin
          state_nxt = IDLE;
        end
      end
      LAUNCH: begin
        state_nxt = HOLD;
      end
      HOLD: begin
        // busy is rising during this cycle, so it is not looked at yet.
        state_nxt = DRAIN;
      end
      DRAIN: begin
        // Launching straight from DRAIN keeps back-to-back frames on a 12-cycle pitch.
        if (!busy) begin
          if (!empty) begin
            txd_in_nxt    = mem[rptr];
            txd_start_nxt = 1'b1;
            pop           = 1'b1;
            state_nxt     = LAUNCH;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          state_nxt = DRAIN;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Occupancy after this edge's write and pop.
  always_comb begin
    level_nxt = level;
    case ({wr_acc, pop})
      2'b10:   level_nxt = level + (AW+1)'(1);
      2'b01:   level_nxt = level - (AW+1)'(1);
      default: level_nxt = level;
    endcase
  end

  // FSM state, launch outputs, pointers and occupancy flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      TxD_start <= 1'b0;
      TxD_in    <= 8'h00;
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
    end else begin
      state     <= state_nxt;
      TxD_start <= txd_start_nxt;
      TxD_in    <= txd_in_nxt;
      if (wr_acc) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      level <= level_nxt;
      full  <= (level_nxt == (AW+1)'(DEPTH));
      empty <= (level_nxt == (AW+1)'(0));
    end
  end

  // Queue storage; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wptr] <= wr_data;
    end
  end

`ifdef RS232_TXQ_OVERFLOW_EN
  // Sticky record of any write attempted while full.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (wr_en && full) begin
      overflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rs232_tx_queue.sv
// Scoreboard bench for rs232_tx_queue with a behavioural serializer that holds busy for 10 cycles.
module tb_rs232_tx_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic [7:0] TxD_in;
  logic       TxD_start;
  logic       busy;
`ifdef RS232_TXQ_OVERFLOW_EN
  logic       overflow;
`endif

  rs232_tx_queue #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en),
    .full(full), .empty(empty), .level(level),
    .TxD_in(TxD_in), .TxD_start(TxD_start), .busy(busy)
`ifdef RS232_TXQ_OVERFLOW_EN
    , .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Serializer model: latches TxD_in on the edge that sees TxD_start, then busy for 10 cycles.
  int         ser_cnt = 0;
  logic       force_busy = 1'b0;
  logic [7:0] ser_q[$];
  always @(posedge clk) begin
    if (TxD_start) begin
      ser_cnt <= 10;
      ser_q.push_back(TxD_in);
    end else if (ser_cnt != 0) begin
      ser_cnt <= ser_cnt - 1;
    end
  end
  assign busy = force_busy | (ser_cnt != 0);

  int chk  = 0;
  int pass = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  logic [7:0] exp_q[$];
  int         pulse_cyc[$];
  int         last_pulse = -1;

  // Monitor: every launch pops the scoreboard and is checked for byte, busy and spacing.
  always @(negedge clk) begin
    if (TxD_start) begin
      check("start_while_busy", {31'd0, busy}, 32'd0);
      if (last_pulse >= 0) check("pulse_gap_ge12", {31'd0, (cyc - last_pulse) >= 12}, 32'd1);
      last_pulse = cyc;
      pulse_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk++;
        $display("FAIL unexpected_launch: TxD_in=%0h with no byte expected", TxD_in);
      end else begin
        check("launch_byte", {24'd0, TxD_in}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic write(input logic [7:0] d, input bit accepted);
    wr_en   = 1'b1;
    wr_data = d;
    if (accepted) exp_q.push_back(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      tick();
      n++;
    end
    check(name, {31'd0, n < 1000}, 32'd1);
    repeat (14) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00;
    repeat (3) tick();
    check("rst_level", {27'd0, level}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_start", {31'd0, TxD_start}, 32'd0);
    check("rst_txd_in", {24'd0, TxD_in}, 32'd0);
    rst = 1'b0;
    tick();

    // 1: single byte, two-cycle launch latency
    write(8'hA5, 1'b1);
    check("t1_no_early_start", {31'd0, TxD_start}, 32'd0);
    tick();
    check("t1_latency", {31'd0, TxD_start}, 32'd1);
    check("t1_empty_after_pop", {31'd0, empty}, 32'd1);
    check("t1_level_after_pop", {27'd0, level}, 32'd0);
    wait_idle("t1_drain");

    // 2: three back-to-back frames
    ser_q.delete();
    pulse_cyc.delete();
    write(8'h01, 1'b1);
    write(8'h02, 1'b1);
    write(8'h03, 1'b1);
    wait_idle("t2_drain");
    check("t2_pulse_count", pulse_cyc.size(), 32'd3);
    if (pulse_cyc.size() == 3) begin
      check("t2_gap01", pulse_cyc[1] - pulse_cyc[0], 32'd12);
      check("t2_gap12", pulse_cyc[2] - pulse_cyc[1], 32'd12);
    end
    check("t2_serial_count", ser_q.size(), 32'd3);
    if (ser_q.size() == 3) begin
      check("t2_serial0", {24'd0, ser_q[0]}, 32'h01);
      check("t2_serial1", {24'd0, ser_q[1]}, 32'h02);
      check("t2_serial2", {24'd0, ser_q[2]}, 32'h03);
    end

    // 3: fill with busy held, then a dropped 17th write
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) write(8'h30 + 8'(i), 1'b1);
    check("t3_level16", {27'd0, level}, 32'd16);
    check("t3_full", {31'd0, full}, 32'd1);
    check("t3_not_empty", {31'd0, empty}, 32'd0);
    write(8'hFF, 1'b0);
    check("t3_level_after_drop", {27'd0, level}, 32'd16);
    check("t3_full_after_drop", {31'd0, full}, 32'd1);
`ifdef RS232_TXQ_OVERFLOW_EN
    check("t3_overflow", {31'd0, overflow}, 32'd1);
`endif
    force_busy = 1'b0;
    wait_idle("t3_drain");

    // 4: 20 bytes written as soon as space exists, across pointer wrap
    n = 0;
    for (int g = 0; g < 2000 && n < 20; g++) begin
      if (!full) begin
        wr_en   = 1'b1;
        wr_data = 8'h80 + 8'(n);
        exp_q.push_back(wr_data);
        n++;
      end else begin
        wr_en = 1'b0;
      end
      tick();
      check("t4_level_le16", {31'd0, level <= 5'd16}, 32'd1);
    end
    wr_en = 1'b0;
    check("t4_all_written", n, 32'd20);
    wait_idle("t4_drain");

    // 5: write and pop on the same edge at level 1
    force_busy = 1'b1;
    write(8'h55, 1'b1);
    tick();
    check("t5_held_level", {27'd0, level}, 32'd1);
    force_busy = 1'b0;
    write(8'h66, 1'b1);
    check("t5_level_stays1", {27'd0, level}, 32'd1);
    check("t5_not_empty", {31'd0, empty}, 32'd0);
    wait_idle("t5_drain");

    // 6: reset in DRAIN with 4 bytes queued
    for (int i = 0; i < 5; i++) write(8'hC0 + 8'(i), 1'b1);
    tick();
    tick();
    check("t6_level_before", {27'd0, level}, 32'd4);
    check("t6_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("t6_level_rst", {27'd0, level}, 32'd0);
    check("t6_empty_rst", {31'd0, empty}, 32'd1);
    check("t6_start_rst", {31'd0, TxD_start}, 32'd0);
    repeat (15) tick();
    check("t6_busy_done", {31'd0, busy}, 32'd0);
    write(8'h77, 1'b1);
    wait_idle("t6_relaunch");

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
